mux_n_1_pipe: RTL

//  Pipelined N:1 data-select tree (N = 2**LOG2_N) with valid/ready flow control.

---
 rtl/mux_n_1_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_n_1_pipe.sv
// Pipelined N:1 select tree with valid/ready flow control; a register stage every
// LEVELS_PER_STAGE 2:1 levels, bubbles collapse, sel travels with the data.
module mux_n_1_pipe #(
    parameter  int WIDTH            = 8,
    parameter  int LOG2_N           = 7,
    parameter  int LEVELS_PER_STAGE = 2,
    localparam int IN_WIDTH         = WIDTH * (1 << LOG2_N),
    localparam int SELW             = (LOG2_N > 0) ? LOG2_N : 1,
    localparam int NUM_STAGES       = (LOG2_N == 0 || LEVELS_PER_STAGE < 1) ? 1
                                      : (LOG2_N + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SELW-1:0]     sel,
    input  logic [IN_WIDTH-1:0] data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    data_out,
    output logic [SELW-1:0]     out_sel
);

    if (LEVELS_PER_STAGE < 1) begin : g_bad_levels
        $error("mux_n_1_pipe: LEVELS_PER_STAGE must be >= 1");
    end

    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES:0]   vchain;
    logic [NUM_STAGES-1:0] rdy;

    assign vchain = {valid_q, in_valid};

    always_comb begin
        rdy = '0;
        rdy[NUM_STAGES-1] = !valid_q[NUM_STAGES-1] || out_ready;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            rdy[NUM_STAGES-1-k] = !valid_q[NUM_STAGES-1-k] || rdy[NUM_STAGES-k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (rdy[k]) valid_q[k] <= vchain[k];
            end
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int IN_LV  = LOG2_N - LEVELS_PER_STAGE * s;
        localparam int OUT_LV = (IN_LV > LEVELS_PER_STAGE) ? IN_LV - LEVELS_PER_STAGE : 0;
        localparam int RES    = IN_LV - OUT_LV;
        localparam int OUT_N  = 1 << OUT_LV;

        logic [(WIDTH << IN_LV)-1:0]  lanes_in;
        logic [(WIDTH << OUT_LV)-1:0] data_d, data_q;
        logic [SELW-1:0]              sel_in, sel_q;

        // The full sel is carried (not just unconsumed bits) so out_sel can report it.
        if (s == 0) begin : g_src
            assign lanes_in = data_in;
            assign sel_in   = (LOG2_N == 0) ? '0 : sel;
        end else begin : g_src
            assign lanes_in = g_stage[s-1].data_q;
            assign sel_in   = g_stage[s-1].sel_q;
        end

        if (RES == 0) begin : g_mux
            assign data_d = lanes_in;
        end else begin : g_mux
            logic [RES-1:0] sub;
            assign sub = sel_in[IN_LV-1 -: RES];
            always_comb begin
                data_d = '0;
                for (int unsigned j = 0; j < OUT_N; j++) begin
                    data_d[j*WIDTH +: WIDTH] = lanes_in[(32'(sub) * OUT_N + j) * WIDTH +: WIDTH];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
                sel_q  <= '0;
            end else if (rdy[s] && vchain[s]) begin
                data_q <= data_d;
                sel_q  <= sel_in;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[NUM_STAGES-1];
    assign data_out  = g_stage[NUM_STAGES-1].data_q;
    assign out_sel   = g_stage[NUM_STAGES-1].sel_q;

endmodule
